act_unit: RTL



---
 rtl/act_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/act_unit.sv
// act_unit: multi-mode activation (identity / ReLU / ReLU6 / hard-sigmoid / hard-swish)
// over LANES fixed-point lanes, with valid/ready flow control and a saturation counter.
module act_unit #(
  parameter int IN_W  = 26,
  parameter int FRAC  = 7,
  parameter int OUT_W = 14,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic [2:0]             in_mode,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   out_last,
  output logic [CNT_W-1:0]       sat_cnt,
  input  logic                   sat_clr
);

  localparam int HW = FRAC + 4;
  localparam int PW = IN_W + FRAC + 5;
  localparam int WW = PW + 16;

  typedef enum logic [2:0] {
    M_IDENT  = 3'd0,
    M_RELU   = 3'd1,
    M_RELU6  = 3'd2,
    M_HSIG   = 3'd3,
    M_HSWISH = 3'd4
  } mode_e;

  localparam logic signed [IN_W:0]   THREE_X = (IN_W+1)'(3 << FRAC);
  localparam logic signed [IN_W:0]   SIX_X   = (IN_W+1)'(6 << FRAC);
  localparam logic [HW-1:0]          SIX_H   = HW'(6 << FRAC);
  localparam logic signed [WW-1:0]   SIX_W   = WW'(6 << FRAC);
  localparam logic signed [WW-1:0]   K_W     = WW'(10923);
  localparam logic signed [WW-1:0]   HS_RND  = WW'(longint'(1) << 15);
  localparam logic signed [WW-1:0]   SW_RND  = WW'(longint'(1) << (FRAC + 15));
  localparam logic signed [WW-1:0]   MAX_O   = WW'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [WW-1:0]   MIN_O   = WW'(-(longint'(1) << (OUT_W - 1)));

  logic advance;
  logic v1, v2, v3, v4;
  logic [2:0] m1, m2, m3, m4;
  logic l1, l2, l3, l4;

  logic signed [IN_W-1:0] x1 [LANES];
  logic signed [IN_W-1:0] x2 [LANES];
  logic signed [IN_W-1:0] x3 [LANES];
  logic signed [IN_W-1:0] x4 [LANES];
  logic [HW-1:0]          h2 [LANES];
  logic [HW-1:0]          h3 [LANES];
  logic signed [PW-1:0]   p3 [LANES];
  logic signed [WW-1:0]   hs4 [LANES];
  logic signed [WW-1:0]   sw4 [LANES];

  logic [HW-1:0]          h_c  [LANES];
  logic signed [PW-1:0]   p_c  [LANES];
  logic signed [WW-1:0]   hs_c [LANES];
  logic signed [WW-1:0]   sw_c [LANES];
  logic [LANES*OUT_W-1:0] o_pk;
  logic [LANES-1:0]       sat_c;
  logic [LANES-1:0]       sat_q;
  logic [CNT_W:0]         inc;
  logic [CNT_W:0]         sum;

  // One global enable: the whole pipe, bubbles included, freezes when the output is held.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    logic signed [IN_W:0] t;
    for (int unsigned i = 0; i < LANES; i++) begin
      t = (IN_W+1)'(x1[i]) + THREE_X;
      if (t < 0)
        h_c[i] = '0;
      else if (t > SIX_X)
        h_c[i] = SIX_H;
      else
        h_c[i] = t[HW-1:0];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      p_c[i] = PW'(x2[i]) * PW'(signed'({1'b0, h2[i]}));
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      hs_c[i] = (WW'(signed'({1'b0, h3[i]})) * K_W + HS_RND) >>> 16;
      sw_c[i] = (WW'(p3[i]) * K_W + SW_RND) >>> (FRAC + 16);
    end
  end

  always_comb begin
    logic signed [WW-1:0] xw;
    logic signed [WW-1:0] r;
    o_pk  = '0;
    sat_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      xw = WW'(x4[i]);
      case (m4)
        M_RELU:   r = (xw < 0) ? '0 : xw;
        M_RELU6:  r = (xw < 0) ? '0 : ((xw > SIX_W) ? SIX_W : xw);
        M_HSIG:   r = hs4[i];
        M_HSWISH: r = sw4[i];
        default:  r = xw;
      endcase
      if (r > MAX_O) begin
        o_pk[i*OUT_W +: OUT_W] = MAX_O[OUT_W-1:0];
        sat_c[i] = 1'b1;
      end else if (r < MIN_O) begin
        o_pk[i*OUT_W +: OUT_W] = MIN_O[OUT_W-1:0];
        sat_c[i] = 1'b1;
      end else begin
        o_pk[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      m1 <= in_mode; m2 <= m1; m3 <= m2; m4 <= m3;
      l1 <= in_last; l2 <= l1; l3 <= l2; l4 <= l3;
      for (int unsigned i = 0; i < LANES; i++) begin
        x1[i]  <= in_data[i*IN_W +: IN_W];
        x2[i]  <= x1[i];
        h2[i]  <= h_c[i];
        x3[i]  <= x2[i];
        h3[i]  <= h2[i];
        p3[i]  <= p_c[i];
        x4[i]  <= x3[i];
        hs4[i] <= hs_c[i];
        sw4[i] <= sw_c[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      v4        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      sat_q     <= '0;
    end else if (advance) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      v4        <= v3;
      out_valid <= v4;
      if (v4) begin
        out_data <= o_pk;
        out_last <= l4;
        sat_q    <= sat_c;
      end
    end
  end

  always_comb begin
    inc = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      inc = inc + (CNT_W+1)'(sat_q[i]);
    end
    sum = {1'b0, sat_cnt} + inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sat_cnt <= '0;
    else if (sat_clr)
      sat_cnt <= '0;
    else if (out_valid && out_ready)
      sat_cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

endmodule
